// File: rtl/idct4x4_ctrl.sv
// 4x4 2-D inverse-DCT sequencer around a shared 4-point 1-D core.
// Ports: clk/rst; in_* row stream in; out_* row stream out; busy; core_* drive/return of the 1-D core.
module idct4x4_ctrl #(
    parameter int WIDTH_X = 16,
    parameter int WIDTH_Y = 22,
    parameter int SHIFT1  = 7,
    parameter int SHIFT2  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*WIDTH_X-1:0]      in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*WIDTH_X-1:0]      out_data,
    output logic                      busy,
    output logic                      core_load,
    output logic signed [WIDTH_X-1:0] core_x0,
    output logic signed [WIDTH_X-1:0] core_x1,
    output logic signed [WIDTH_X-1:0] core_x2,
    output logic signed [WIDTH_X-1:0] core_x3,
    input  logic signed [WIDTH_Y-1:0] core_y0,
    input  logic signed [WIDTH_Y-1:0] core_y1,
    input  logic signed [WIDTH_Y-1:0] core_y2,
    input  logic signed [WIDTH_Y-1:0] core_y3
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_PASS1,
        S_PASS2,
        S_DRAIN
    } state_t;

    localparam int SMAX_I  = 2 ** (WIDTH_X - 1) - 1;
    localparam int SMIN_I  = -(2 ** (WIDTH_X - 1));
    localparam int HALF1_I = 2 ** (SHIFT1 - 1);
    localparam int HALF2_I = 2 ** (SHIFT2 - 1);
    localparam logic signed [WIDTH_Y:0] SMAX  = SMAX_I[WIDTH_Y:0];
    localparam logic signed [WIDTH_Y:0] SMIN  = SMIN_I[WIDTH_Y:0];
    localparam logic signed [WIDTH_Y:0] HALF1 = HALF1_I[WIDTH_Y:0];
    localparam logic signed [WIDTH_Y:0] HALF2 = HALF2_I[WIDTH_Y:0];

    state_t     state_q, state_d;
    logic [1:0] row_q, row_d;
    logic [2:0] cnt_q, cnt_d;
    logic       c_we, e_we, o_we;
    logic [1:0] cap_idx;

    logic signed [WIDTH_X-1:0] c_q [4][4];
    logic signed [WIDTH_X-1:0] e_q [4][4];
    logic signed [WIDTH_X-1:0] o_q [4][4];
    logic signed [WIDTH_X-1:0] cx  [4];
    logic signed [WIDTH_Y-1:0] y   [4];

    // Round half up, arithmetic (floor) shift, clip to sample range.
    // Sign extension by one bit keeps the rounding add from overflowing.
    function automatic logic signed [WIDTH_X-1:0] rnd_sat(
        input logic signed [WIDTH_Y-1:0] v,
        input logic signed [WIDTH_Y:0]   half,
        input int                        sh
    );
        logic signed [WIDTH_Y:0] t;
        t = {v[WIDTH_Y-1], v} + half;
        t = t >>> sh;
        if (t > SMAX) begin
            rnd_sat = SMAX[WIDTH_X-1:0];
        end else if (t < SMIN) begin
            rnd_sat = SMIN[WIDTH_X-1:0];
        end else begin
            rnd_sat = t[WIDTH_X-1:0];
        end
    endfunction

    assign y[0] = core_y0;
    assign y[1] = core_y1;
    assign y[2] = core_y2;
    assign y[3] = core_y3;

    // Results of the load issued at cnt appear at cnt+2.
    assign cap_idx = cnt_q[1:0] - 2'd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            row_q   <= 2'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        core_load = 1'b0;
        c_we      = 1'b0;
        e_we      = 1'b0;
        o_we      = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    c_we  = 1'b1;
                    row_d = row_q + 2'd1;
                    if (row_q == 2'd3) begin
                        state_d = S_PASS1;
                        cnt_d   = 3'd0;
                    end
                end
            end
            S_PASS1, S_PASS2: begin
                core_load = (cnt_q < 3'd4);
                if (cnt_q >= 3'd2) begin
                    e_we = (state_q == S_PASS1);
                    o_we = (state_q == S_PASS2);
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    cnt_d   = 3'd0;
                    row_d   = 2'd0;
                    state_d = (state_q == S_PASS1) ? S_PASS2 : S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    row_d = row_q + 2'd1;
                    if (row_q == 2'd3) begin
                        state_d = S_LOAD;
                    end
                end
            end
        endcase
    end

    // Sample buffers carry no reset; the control path alone decides validity.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (c_we) begin
                c_q[row_q][k] <= in_data[k*WIDTH_X +: WIDTH_X];
            end
            if (e_we) begin
                e_q[k][cap_idx] <= rnd_sat(y[k], HALF1, SHIFT1);
            end
            if (o_we) begin
                o_q[cap_idx][k] <= rnd_sat(y[k], HALF2, SHIFT2);
            end
        end
    end

    // Vertical pass feeds columns of C, horizontal pass feeds rows of E.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cx[k] = '0;
            if (core_load) begin
                if (state_q == S_PASS1) begin
                    cx[k] = c_q[k][cnt_q[1:0]];
                end else begin
                    cx[k] = e_q[cnt_q[1:0]][k];
                end
            end
        end
    end

    assign core_x0 = cx[0];
    assign core_x1 = cx[1];
    assign core_x2 = cx[2];
    assign core_x3 = cx[3];

    always_comb begin
        out_data = '0;
        if (state_q == S_DRAIN) begin
            for (int k = 0; k < 4; k++) begin
                out_data[k*WIDTH_X +: WIDTH_X] = o_q[row_q][k];
            end
        end
    end

    assign busy = (state_q != S_LOAD) || (row_q != 2'd0);

endmodule

// File: tb/tb_idct4x4_ctrl.sv
// Bench for idct4x4_ctrl with a behavioural 1-D core and a 2-D model.
// Scoreboard compares every output row; timing/stability checks run each cycle.
module tb_idct4x4_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
    logic        core_load;
    logic signed [15:0] core_x0, core_x1, core_x2, core_x3;
    logic signed [21:0] core_y0, core_y1, core_y2, core_y3;

    idct4x4_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .core_load (core_load),
        .core_x0   (core_x0),
        .core_x1   (core_x1),
        .core_x2   (core_x2),
        .core_x3   (core_x3),
        .core_y0   (core_y0),
        .core_y1   (core_y1),
        .core_y2   (core_y2),
        .core_y3   (core_y3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    // HEVC 4-point inverse DCT, element k.
    function automatic longint idct_el(input longint a, input longint b,
                                       input longint c, input longint d,
                                       input int k);
        longint e0, e1, o0, o1;
        e0 = 64 * (a + c);
        e1 = 64 * (a - c);
        o0 = 83 * b + 36 * d;
        o1 = 36 * b - 83 * d;
        case (k)
            0:       idct_el = e0 + o0;
            1:       idct_el = e1 + o1;
            2:       idct_el = e1 - o1;
            default: idct_el = e0 - o0;
        endcase
    endfunction

    function automatic longint rs(input longint v, input int s);
        longint t;
        t = (v + (longint'(1) << (s - 1))) >>> s;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        rs = t;
    endfunction

    function automatic void model(input logic [63:0] ci [4],
                                  output logic [63:0] oo [4]);
        longint c [4][4];
        longint e [4][4];
        longint v;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                c[i][k] = longint'($signed(ci[i][k*16 +: 16]));
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++)
                e[k][j] = rs(idct_el(c[0][j], c[1][j], c[2][j], c[3][j], k), 7);
        for (int i = 0; i < 4; i++) begin
            oo[i] = '0;
            for (int k = 0; k < 4; k++) begin
                v = rs(idct_el(e[i][0], e[i][1], e[i][2], e[i][3], k), 12);
                oo[i][k*16 +: 16] = 16'(v);
            end
        end
    endfunction

    function automatic logic [63:0] pk(input int a, input int b,
                                       input int c, input int d);
        pk = {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Behavioural core: operands registered, result registered next edge.
    logic signed [15:0] xr [4];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) xr[k] <= '0;
            core_y0 <= '0;
            core_y1 <= '0;
            core_y2 <= '0;
            core_y3 <= '0;
        end else begin
            xr[0] <= core_x0;
            xr[1] <= core_x1;
            xr[2] <= core_x2;
            xr[3] <= core_x3;
            core_y0 <= 22'(idct_el(xr[0], xr[1], xr[2], xr[3], 0));
            core_y1 <= 22'(idct_el(xr[0], xr[1], xr[2], xr[3], 1));
            core_y2 <= 22'(idct_el(xr[0], xr[1], xr[2], xr[3], 2));
            core_y3 <= 22'(idct_el(xr[0], xr[1], xr[2], xr[3], 3));
        end
    end

    int cyc;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] in_buf [4];
    logic [63:0] exp_blk [4];
    logic [63:0] expq [$];
    int          in_n = 0;
    int          out_n = 0;
    int          hs3_cyc = 0;
    int          r0_cyc = 0;
    bit          r0_seen = 0;
    bit          b2b = 0;
    int          cl_cnt = 0;
    bit          prev_ov = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_od = '0;
    bit          inflight = 0;
    bit          bp_arm = 0;
    int          bp_cnt = 0;

    // Compare process, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            in_n = 0;
            expq.delete();
            inflight = 0;
            prev_ov = 0;
            prev_stall = 0;
            r0_seen = 0;
            cl_cnt = 0;
            out_n = 0;
        end else begin
            if (core_load) cl_cnt++;
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", out_data, prev_od);
            end
            if (out_valid) begin
                chk("drain_in_ready", 64'(in_ready), 64'd0);
                chk("drain_core_load", 64'(core_load), 64'd0);
            end
            // Row 3 accepted at edge cyc+1; out_valid due after 12 more edges.
            if (out_valid && !prev_ov) begin
                chk("latency", 64'(cyc - hs3_cyc), 64'd13);
                chk("core_loads", 64'(cl_cnt), 64'd8);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    fail_now("unexpected_out_row");
                end else begin
                    chk("out_row", out_data, expq.pop_front());
                end
                out_n++;
                if (expq.size() == 0) inflight = 0;
                if (bp_arm && (out_n % 4 == 1)) begin
                    bp_cnt = 5;
                    bp_arm = 0;
                end
            end
            if (in_valid && in_ready) begin
                if (in_n == 0) begin
                    chk("in_after_drain", 64'(inflight), 64'd0);
                    if (b2b && r0_seen)
                        chk("period", 64'(cyc - r0_cyc), 64'd20);
                    r0_cyc = cyc;
                    r0_seen = 1;
                end
                in_buf[in_n] = in_data;
                in_n++;
                if (in_n == 4) begin
                    model(in_buf, exp_blk);
                    for (int i = 0; i < 4; i++) expq.push_back(exp_blk[i]);
                    in_n = 0;
                    inflight = 1;
                    hs3_cyc = cyc;
                    cl_cnt = 0;
                end
            end
            prev_ov = out_valid;
            prev_stall = out_valid && !out_ready;
            prev_od = out_data;
        end
    end

    // Sink: ready unless a backpressure window is pending.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_cnt > 0) begin
                out_ready = 1'b0;
                bp_cnt--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic send_row(input logic [63:0] d);
        int n;
        in_valid = 1'b1;
        in_data = d;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("in_ready_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic send_blk(input logic [63:0] b [4]);
        for (int r = 0; r < 4; r++) send_row(b[r]);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((inflight || expq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (inflight || expq.size() != 0) fail_now("drain_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_core_load", 64'(core_load), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [63:0] b_dc64 [4];
    logic [63:0] b_dc512 [4];
    logic [63:0] b_neg [4];
    logic [63:0] b_ac [4];
    logic [63:0] b_mix [4];
    logic [63:0] mo [4];

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;

        b_dc64  = '{pk(64, 0, 0, 0), 64'd0, 64'd0, 64'd0};
        b_dc512 = '{pk(512, 0, 0, 0), 64'd0, 64'd0, 64'd0};
        b_neg   = '{pk(-64, 0, 0, 0), 64'd0, 64'd0, 64'd0};
        b_ac    = '{pk(0, 64, 0, 0), 64'd0, 64'd0, 64'd0};
        b_mix   = '{pk(300, -120, 45, -7), pk(-80, 60, 0, 12),
                    pk(25, -33, 90, 4), pk(0, 17, -50, 200)};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_core_load", 64'(core_load), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_out_data", out_data, 64'd0);
        chk("reset_core_x", {core_x3, core_x2, core_x1, core_x0}, 64'd0);

        // Pin the model with hand-computed blocks.
        model(b_dc64, mo);
        chk("model_dc64", mo[2], 64'h0001_0001_0001_0001);
        model(b_dc512, mo);
        chk("model_dc512", mo[1], 64'h0004_0004_0004_0004);
        model(b_neg, mo);
        chk("model_neg64", mo[3], 64'h0000_0000_0000_0000);
        model(b_ac, mo);
        chk("model_ac", mo[0], 64'hFFFF_0000_0000_0001);
        @(posedge clk);
        #1;

        send_blk(b_dc64);
        idle_in();
        @(negedge clk);
        chk("busy_compute", 64'(busy), 64'd1);
        wait_idle();
        send_blk(b_dc512);
        idle_in();
        wait_idle();
        send_blk(b_neg);
        idle_in();
        wait_idle();
        send_blk(b_ac);
        idle_in();
        wait_idle();
        send_blk(b_mix);
        idle_in();
        wait_idle();

        bp_arm = 1;
        send_blk(b_mix);
        idle_in();
        wait_idle();

        b2b = 1;
        r0_seen = 0;
        send_blk(b_dc64);
        send_blk(b_mix);
        send_blk(b_ac);
        idle_in();
        wait_idle();
        b2b = 0;

        send_blk(b_dc512);
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        pulse_rst();
        send_row(b_mix[0]);
        send_row(b_mix[1]);
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        pulse_rst();
        send_blk(b_dc64);
        idle_in();
        wait_idle();
        repeat (30) @(posedge clk);
        #1;
        chk("final_idle_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/idct4x4_ctrl.md
# idct4x4_ctrl

Sequencer that turns one shared 4-point 1-D inverse-DCT core into a 4x4 2-D inverse transform. Buffers a 4x4 coefficient block arriving row by row. Runs a vertical pass (4 columns) and then a horizontal pass (4 rows) through the core, with HEVC rounding/shift/clip between stages. Returns the residual block row by row over a valid/ready stream. Sits between the coefficient parser and reconstruction; the 1-D core is instantiated beside it at top level, shares clk/rst, and is driven only by this block.

## Interface
- WIDTH_X, 16, coefficient/residual sample width; also the core input width
- WIDTH_Y, 22, core output width
- SHIFT1, 7, stage-1 right shift
- SHIFT2, 12, stage-2 right shift
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input row valid
- in_ready  out  1  block can accept an input row
- in_data  in  4*WIDTH_X  coefficient row; element k at [k*WIDTH_X +: WIDTH_X], signed
- out_valid  out  1  output row valid
- out_ready  in  1  downstream accepts row
- out_data  out  4*WIDTH_X  residual row, same packing, signed
- busy  out  1  high in any state other than LOAD, or in LOAD with ≥1 row held
- core_load  out  1  load strobe to the core
- core_x0..core_x3  out  WIDTH_X each  core operands
- core_y0..core_y3  in  WIDTH_Y each  core results (registered in core)

## Operation
- States: LOAD, PASS1, PASS2, DRAIN.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready edge writes row r (counter 0..3) of input buffer C.
  - Handshake on r=3 goes to PASS1 with cnt=0.
- PASS1 (cnt 0..5):
  - cnt 0..3: core_load=1 and core_x0..3 = C[0..3][cnt] (column cnt).
  - cnt 2..5: capture core_y0..3 into intermediate E[0..3][cnt-2].
  - Each captured value is e = sat_WIDTH_X((y + 2^(SHIFT1-1)) >>> SHIFT1).
  - cnt=5 goes to PASS2 with cnt=0.
- PASS2 (cnt 0..5):
  - cnt 0..3: core_load=1 and core_x0..3 = E[cnt][0..3] (row cnt).
  - cnt 2..5: capture into output buffer O[cnt-2][0..3] as sat_WIDTH_X((y + 2^(SHIFT2-1)) >>> SHIFT2).
  - cnt=5 goes to DRAIN with row=0.
- DRAIN:
  - out_valid=1 and out_data=O[row].
  - Row advances on out_valid&out_ready.
  - Handshake on row=3 returns to LOAD.
  - in_ready=0 throughout DRAIN.
- Arithmetic:
  - Rounding add is done at WIDTH_Y+1 bits.
  - Arithmetic shift, floor toward −inf.
  - Saturate to [−2^(WIDTH_X−1), 2^(WIDTH_X−1)−1].
- core_load=0 implies core_x0..3=0.
- Reset values: all outputs 0 except in_ready=1; state LOAD; all counters 0. Buffers C/E/O are not reset.
- rst mid-operation: any partial input block or in-flight pass is discarded. The next accepted row is row 0 of a new block.
- out_data is held stable while out_valid&!out_ready.

## Timing
- Core contract: operands with core_load=1 in cycle c produce results on core_y during cycle c+2. The controller must capture exactly then.
- One core load per cycle, 4 consecutive per pass, no bubbles.
- Let E0 be the edge accepting input row 3:
  - PASS1 occupies edges E0..E0+6.
  - PASS2 occupies edges E0+6..E0+12.
  - out_valid rises after edge E0+12.
- Minimum block period with in_valid and out_ready held high is 20 cycles: 4 load + 12 compute + 4 drain.
- in_ready returns to 1 the cycle after the edge that accepts output row 3.
- in_valid is ignored outside LOAD. out_ready is ignored outside DRAIN.

## Test plan
- DC block, C[0][0]=64 and all others 0, in_valid and out_ready held high. Required:
  - 4 output rows of [1,1,1,1].
  - out_valid first high exactly 12 edges after the last input handshake.
- Block with C[0][0]=512, rest 0. Required: all outputs 4. Block with C[0][0]=−64, rest 0. Required: all outputs 0, which checks floor rounding of −31.5 to −32 in stage 1.
- Single AC term, C[0][1]=64, rest 0. Required: every output row is [1,0,0,−1].
- Backpressure: out_ready low for 5 cycles at row 1. Required:
  - out_data stays row 1 and out_valid stays 1.
  - in_ready stays 0 and core_load stays 0.
  - The rows that follow are in order.
- Back-to-back blocks with in_valid always high. Required:
  - Second block rows are accepted only after output row 3 is accepted.
  - Period is 20 cycles.
  - core_load high exactly 8 cycles per block.
- rst asserted during PASS1 and again after 2 input rows. Required:
  - in_ready=1, out_valid=0, core_load=0 after reset.
  - A following DC=64 block produces all-ones output with no residue of the aborted block.
